// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI target block: data widths, the default byte
// sent when nothing is queued for transmit, and the mode-0 pin polarities.
// No ports; imported by sync_fifo and spi_target.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_BYTE_W   = 8;
    localparam int SPI_BITCNT_W = 3;

    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;

    // Mode 0: SCK idles low; the rising edge samples, the falling edge shifts.
    localparam logic SCK_IDLE       = 1'b0;
    localparam logic SCK_SAMPLE_LVL = 1'b1;   // SCK level just after the sampling edge
    localparam logic CSN_IDLE       = 1'b1;   // chip select is active-low

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered empty/full flags.
//
// Handshake: a read fires when rd_valid && rd_ready; a write is accepted when
// wr_valid && (wr_ready || a read fires in the same cycle), so a full FIFO can
// take a new entry in the cycle its head leaves. Callers that need a strict
// valid/ready write must gate wr_valid with wr_ready themselves.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   wr_valid/wr_ready    write request / not full (registered)
//   wr_data              entry to enqueue
//   rd_valid/rd_ready    not empty (registered) / pop head
//   rd_data              head entry
// ---------------------------------------------------------------------------
module sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH   = SPI_BYTE_W,
    parameter int LGDEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << LGDEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [LGDEPTH:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic             full_q, empty_q, full_nxt, empty_nxt;
    logic             wr_fire, rd_fire;

    assign rd_valid = !empty_q;
    assign wr_ready = !full_q;
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_fire  = wr_valid && (!full_q || rd_fire);
    assign rd_data  = mem[rd_ptr[LGDEPTH-1:0]];

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{LGDEPTH{1'b0}}, wr_fire};
        rd_ptr_nxt = rd_ptr + {{LGDEPTH{1'b0}}, rd_fire};
        full_nxt   = (wr_ptr_nxt[LGDEPTH] != rd_ptr_nxt[LGDEPTH]) &&
                     (wr_ptr_nxt[LGDEPTH-1:0] == rd_ptr_nxt[LGDEPTH-1:0]);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            full_q  <= full_nxt;
            empty_q <= empty_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[LGDEPTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_target.sv
// ---------------------------------------------------------------------------
// spi_target
// SPI mode-0 target, MSB first. The SPI pins are oversampled in the clk
// domain; received bytes go to an RX FIFO and transmit bytes come from a TX
// FIFO, both with valid/ready handshakes toward local logic.
//
// Ports:
//   clk, resetn               system clock, asynchronous active-low reset
//   spi_clk/spi_csn/spi_mosi  asynchronous pins from the controller
//   spi_miso, spi_miso_oe     data to controller, driven while selected
//   rx_data/rx_valid/rx_ready RX FIFO head, pop on rx_valid && rx_ready
//   tx_data/tx_valid/tx_ready TX FIFO push on tx_valid && tx_ready
//   rx_overrun, tx_underrun   sticky error flags, cleared by flags_clear
//   frame_active, frame_end   selected status / one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module spi_target
    import spi_pkg::*;
#(
    parameter int                    RX_LGDEPTH  = 2,
    parameter int                    TX_LGDEPTH  = 2,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    input  logic                  flags_clear,
    output logic                  frame_active,
    output logic                  frame_end
);

    // ---------------- pin synchronizers ----------------
    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic                   sck_prev, csn_prev;
    // Fills with ones after reset; its top bit means csn_prev holds a real
    // pin sample rather than the reset preset, so a CSN held low across reset
    // is not mistaken for a select edge.
    logic [SYNC_STAGES:0]   primed;
    logic                   sck_s, csn_s, mosi_s, edges_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            csn_sync  <= {SYNC_STAGES{CSN_IDLE}};
            mosi_sync <= '0;
            sck_prev  <= SCK_IDLE;
            csn_prev  <= CSN_IDLE;
            primed    <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            csn_prev  <= csn_s;
            primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign edges_ok = primed[SYNC_STAGES];

    // ---------------- edge events ----------------
    logic csn_fall, csn_rise, sck_rise, sck_fall;

    assign csn_fall = edges_ok && (csn_prev == CSN_IDLE) && (csn_s != CSN_IDLE);
    assign csn_rise = edges_ok && (csn_prev != CSN_IDLE) && (csn_s == CSN_IDLE);
    // Deselect takes priority over any SCK edge seen in the same cycle.
    assign sck_rise = frame_active && !csn_rise &&
                      (sck_s == SCK_SAMPLE_LVL) && (sck_prev != SCK_SAMPLE_LVL);
    assign sck_fall = frame_active && !csn_rise &&
                      (sck_s != SCK_SAMPLE_LVL) && (sck_prev == SCK_SAMPLE_LVL);

    // ---------------- datapath ----------------
    logic [SPI_BITCNT_W-1:0] bit_cnt;
    logic [SPI_BYTE_W-1:0]   tx_shift, rx_shift, rx_byte, tx_head, tx_next;
    logic                    byte_load, rx_push, rx_pop, rx_fifo_ready;
    logic                    tx_head_valid, tx_push;
    logic                    overrun_set, underrun_set;

    assign byte_load = !csn_rise && (csn_fall || (sck_fall && bit_cnt == '0));
    // TX emptiness is judged before this cycle's push lands.
    assign tx_next   = tx_head_valid ? tx_head : IDLE_BYTE;
    assign tx_push   = tx_valid && tx_ready;

    assign rx_byte   = {rx_shift[SPI_BYTE_W-2:0], mosi_s};
    assign rx_push   = sck_rise && (bit_cnt == '1);
    assign rx_pop    = rx_valid && rx_ready;

    // A full RX FIFO still takes the byte if its head is popped this cycle.
    assign overrun_set  = rx_push && !rx_fifo_ready && !rx_pop;
    assign underrun_set = byte_load && !tx_head_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt      <= '0;
            tx_shift     <= IDLE_BYTE;
            rx_shift     <= '0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (csn_rise) begin
                // Only a frame that was actually selected reports its end.
                frame_end    <= frame_active;
                frame_active <= 1'b0;
                bit_cnt      <= '0;
            end else if (csn_fall) begin
                frame_active <= 1'b1;
                bit_cnt      <= '0;
                tx_shift     <= tx_next;
            end else if (sck_rise) begin
                rx_shift <= rx_byte;
                bit_cnt  <= SPI_BITCNT_W'(bit_cnt + 1'b1);
            end else if (sck_fall) begin
                if (bit_cnt == '0) begin
                    tx_shift <= tx_next;
                end else begin
                    tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                end
            end
            // A set event in the same cycle as a clear leaves the flag set.
            rx_overrun  <= overrun_set  || (rx_overrun  && !flags_clear);
            tx_underrun <= underrun_set || (tx_underrun && !flags_clear);
        end
    end

    assign spi_miso    = frame_active ? tx_shift[SPI_BYTE_W-1] : 1'b1;
    assign spi_miso_oe = frame_active;

    // ---------------- FIFOs ----------------
    sync_fifo #(.WIDTH(SPI_BYTE_W), .LGDEPTH(RX_LGDEPTH)) u_rx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (rx_push),
        .wr_ready (rx_fifo_ready),
        .wr_data  (rx_byte),
        .rd_valid (rx_valid),
        .rd_ready (rx_ready),
        .rd_data  (rx_data)
    );

    sync_fifo #(.WIDTH(SPI_BYTE_W), .LGDEPTH(TX_LGDEPTH)) u_tx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (tx_push),
        .wr_ready (tx_ready),
        .wr_data  (tx_data),
        .rd_valid (tx_head_valid),
        .rd_ready (byte_load),
        .rd_data  (tx_head)
    );

endmodule

// File: tb/tb_spi_target.sv
// ---------------------------------------------------------------------------
// tb_spi_target
// Drives spi_target as an SPI mode-0 controller. A queue-based model of the
// TX FIFO, RX FIFO occupancy and sticky flags predicts what the target must
// return; an RX monitor pops the expected-byte queue whenever the target
// hands a byte over on rx_valid/rx_ready.
// ---------------------------------------------------------------------------
module tb_spi_target;

    localparam int         SYNC  = 2;
    localparam int         HALF  = SYNC + 3;   // SCK half period in clk cycles
    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'hFF;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       resetn;
    logic       spi_clk, spi_csn, spi_mosi, spi_miso, spi_miso_oe;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic       rx_overrun, tx_underrun, flags_clear, frame_active, frame_end;

    always #5 clk = ~clk;

    spi_target #(
        .RX_LGDEPTH (2),
        .TX_LGDEPTH (2),
        .SYNC_STAGES(SYNC),
        .IDLE_BYTE  (IDLE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi_clk     (spi_clk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .flags_clear (flags_clear),
        .frame_active(frame_active),
        .frame_end   (frame_end)
    );

    // ---------------- scoreboard and reference model ----------------
    logic [7:0] exp_q[$];      // bytes the target must deliver on rx_data
    logic [7:0] tx_q[$];       // bytes held in the target's TX FIFO
    logic [7:0] cur_tx;        // byte the target is currently shifting out
    logic [7:0] mon_exp;
    bit         sel;           // target is selected
    bit         exp_over, exp_under;
    int         exp_fe, fe_cnt;
    int         n_checks, n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // RX monitor: a byte leaves the FIFO at the posedge following a negedge
    // that sees rx_valid && rx_ready (rx_ready only changes just after posedge).
    always @(negedge clk) begin
        if (frame_end) fe_cnt++;
        if (rx_valid && rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rx_data: got %02h, expected no byte", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rx_data === mon_exp) n_pass++;
                else $display("FAIL rx_data: got %02h, expected %02h", rx_data, mon_exp);
            end
        end
    end

    // At every byte start the target takes the TX head, or IDLE if empty.
    task automatic model_load();
        if (tx_q.size() > 0) begin
            cur_tx = tx_q.pop_front();
        end else begin
            cur_tx    = IDLE;
            exp_under = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx_ready(input logic v);
        rx_ready = v;
        wait_clks(1);
    endtask

    task automatic tx_push(input logic [7:0] b);
        check("tx_ready", tx_ready, (tx_q.size() < DEPTH));
        tx_data  = b;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
    endtask

    task automatic clear_flags();
        flags_clear = 1'b1;
        wait_clks(1);
        flags_clear = 1'b0;
        exp_over    = 1'b0;
        exp_under   = 1'b0;
        wait_clks(1);
        check("rx_overrun_cleared", rx_overrun, exp_over);
        check("tx_underrun_cleared", tx_underrun, exp_under);
    endtask

    task automatic check_flags();
        check("rx_overrun", rx_overrun, exp_over);
        check("tx_underrun", tx_underrun, exp_under);
    endtask

    task automatic frame_begin();
        spi_csn = 1'b0;
        sel     = 1'b1;
        model_load();
        wait_clks(HALF);
        check("frame_active_sel", frame_active, 1);
        check("miso_oe_sel", spi_miso_oe, 1);
    endtask

    task automatic frame_finish();
        wait_clks(HALF);
        spi_csn = 1'b1;
        if (sel) exp_fe++;
        sel = 1'b0;
        wait_clks(2 * HALF);
        check("frame_active_desel", frame_active, 0);
        check("miso_oe_desel", spi_miso_oe, 0);
        check("frame_end_pulses", fe_cnt, exp_fe);
    endtask

    // One byte (or nbits < 8 of it) MSB first. In loopback the controller
    // echoes MISO onto MOSI, so the target must receive what it sent.
    task automatic xfer(input logic [7:0] data, input int nbits, input bit loop, input bit lat_chk);
        logic [7:0] got, miso_exp, rx_exp;
        got      = '0;
        miso_exp = sel ? cur_tx : IDLE;
        rx_exp   = loop ? miso_exp : data;
        for (int i = 0; i < nbits; i++) begin
            if (!loop) spi_mosi = data[7-i];
            wait_clks(HALF - 1);
            got = {got[6:0], spi_miso};
            if (loop) spi_mosi = spi_miso;
            wait_clks(1);
            spi_clk = 1'b1;
            if (i == 7 && sel) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(rx_exp);
                else exp_over = 1'b1;
            end
            if (i == 7 && lat_chk) begin
                wait_clks(SYNC);
                check("rx_valid_before_latency", rx_valid, 0);
                wait_clks(1);
                check("rx_valid_at_latency", rx_valid, 1);
                check("tx_underrun_mid_frame", tx_underrun, exp_under);
                wait_clks(HALF - SYNC - 1);
            end else begin
                wait_clks(HALF);
            end
            spi_clk = 1'b0;
            if (i == 7 && sel) model_load();
        end
        if (nbits == 8) check("miso_byte", got, miso_exp);
    endtask

    task automatic check_reset_vals();
        check("rst_spi_miso", spi_miso, 1);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_overrun", rx_overrun, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frame_end", frame_end, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nb, np;
        bit lp;
        resetn = 1'b0; spi_clk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0; flags_clear = 1'b0;
        sel = 1'b0; exp_over = 1'b0; exp_under = 1'b0; cur_tx = IDLE;
        exp_fe = 0; fe_cnt = 0; n_checks = 0; n_pass = 0;
        wait_clks(3);
        check_reset_vals();
        resetn = 1'b1;
        wait_clks(HALF);

        // 1: single byte each way, receive latency
        tx_push(8'hA5);
        frame_begin();
        xfer(8'h3C, 8, 1'b0, 1'b1);
        frame_finish();
        check_flags();
        clear_flags();

        // 2: TX empty -> IDLE bytes and underrun
        frame_begin();
        xfer(8'h5A, 8, 1'b0, 1'b0);
        xfer(8'hC3, 8, 1'b0, 1'b0);
        frame_finish();
        check_flags();
        clear_flags();

        // 3: RX overflow with no pops, then drain in order
        set_rx_ready(1'b0);
        frame_begin();
        for (int i = 1; i <= 5; i++) xfer(8'(i), 8, 1'b0, 1'b0);
        frame_finish();
        check_flags();
        check("rx_valid_held", rx_valid, 1);
        set_rx_ready(1'b1);
        wait_clks(8);
        check("rx_drained", exp_q.size(), 0);
        check("rx_valid_after_drain", rx_valid, 0);
        clear_flags();

        // 4: partial byte discarded, next frame aligned
        frame_begin();
        xfer(8'hF0, 4, 1'b0, 1'b0);
        frame_finish();
        check("rx_no_partial_push", rx_valid, 0);
        frame_begin();
        xfer(8'h81, 8, 1'b0, 1'b0);
        frame_finish();
        clear_flags();

        // 5: loopback with TX preloaded
        tx_push(8'h11);
        tx_push(8'h22);
        tx_push(8'h33);
        frame_begin();
        for (int i = 0; i < 3; i++) xfer(8'h00, 8, 1'b1, 1'b0);
        frame_finish();
        check_flags();
        clear_flags();

        // 7: TX full refuses a fifth byte
        for (int i = 0; i < 5; i++) tx_push(8'hC0 + 8'(i));
        frame_begin();
        for (int i = 0; i < 4; i++) xfer(8'($urandom_range(0, 255)), 8, 1'b0, 1'b0);
        frame_finish();
        check_flags();
        clear_flags();

        // 6: reset in the middle of a byte while CSN stays low
        set_rx_ready(1'b0);
        tx_push(8'h9E);
        frame_begin();
        xfer(8'h77, 8, 1'b0, 1'b0);
        xfer(8'h12, 4, 1'b0, 1'b0);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        tx_q.delete();
        sel = 1'b0; exp_over = 1'b0; exp_under = 1'b0;
        spi_clk = 1'b0;
        wait_clks(3);
        resetn = 1'b1;
        rx_ready = 1'b1;
        wait_clks(HALF);
        xfer(8'h66, 8, 1'b0, 1'b0);
        wait_clks(HALF);
        check("post_reset_rx_valid", rx_valid, 0);
        check("post_reset_frame_active", frame_active, 0);
        frame_finish();
        frame_begin();
        xfer(8'h5A, 8, 1'b0, 1'b0);
        frame_finish();
        check_flags();
        clear_flags();

        // random frames against the model
        for (int f = 0; f < 8; f++) begin
            np = $urandom_range(0, 3);
            for (int i = 0; i < np; i++) tx_push(8'($urandom_range(0, 255)));
            nb = $urandom_range(1, 3);
            lp = 1'($urandom_range(0, 1));
            frame_begin();
            for (int i = 0; i < nb; i++) xfer(8'($urandom_range(0, 255)), 8, lp, 1'b0);
            frame_finish();
            check_flags();
            if ($urandom_range(0, 1) == 1) clear_flags();
        end

        wait_clks(20);
        check("rx_all_delivered", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
